// File: rtl/literal_emitter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : literal_emitter_pkg
// Brief    : Shared state encoding, ASCII constants and elaboration-time
//            helpers for turning the value width into decimal digits.
// Revision : 1.0 - initial release
// ============================================================================
package literal_emitter_pkg;

  // Emitter states; 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WIDTH = 3'd1,
    ST_TICK  = 3'd2,
    ST_SIGN  = 3'd3,
    ST_BASE  = 3'd4,
    ST_DIGIT = 3'd5,
    ST_SEP   = 3'd6
  } state_e;

  localparam logic [7:0] c_ASCII_TICK = 8'h27;  // '
  localparam logic [7:0] c_ASCII_S    = 8'h73;  // s
  localparam logic [7:0] c_ASCII_H    = 8'h68;  // h
  localparam logic [7:0] c_ASCII_US   = 8'h5F;  // _
  localparam logic [7:0] c_ASCII_0    = 8'h30;  // 0
  localparam logic [7:0] c_ASCII_LA   = 8'h61;  // a
  localparam logic [7:0] c_ASCII_UA   = 8'h41;  // A

  // Widths up to 9999 need at most four decimal digits.
  localparam int c_DEC_MAX = 4;

  // Number of decimal digits of w (w >= 1).
  function automatic int dec_count(input int w);
    int n;
    int p;
    n = 1;
    p = 10;
    for (int i = 1; i < c_DEC_MAX; i++) begin
      if (w >= p) n = i + 1;
      p = p * 10;
    end
    return n;
  endfunction

  // Decimal digits of w, most significant digit in the top nibble,
  // left-aligned; unused trailing nibbles are zero.
  function automatic logic [4*c_DEC_MAX-1:0] dec_digits(input int w);
    logic [4*c_DEC_MAX-1:0] r;
    int v;
    int n;
    r = '0;
    v = w;
    n = dec_count(w);
    for (int i = c_DEC_MAX - 1; i >= 0; i--) begin
      if (i < n) begin
        r[(c_DEC_MAX-1-i)*4 +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/literal_emitter_hex_ascii.sv
`default_nettype none
// ============================================================================
// Module   : hex_ascii
// Brief    : Combinational nibble-to-ASCII converter (0-9, a-f or A-F).
// Revision : 1.0 - initial release
// ============================================================================
module hex_ascii
  import literal_emitter_pkg::*;
#(
  parameter int UPPER = 0
) (
  input  logic [3:0] i_nib,
  output logic [7:0] o_char
);

  localparam logic [7:0] c_ALPHA = (UPPER != 0) ? c_ASCII_UA : c_ASCII_LA;

  // Map the nibble onto the digit or letter range.
  always_comb begin
    if (i_nib < 4'd10) o_char = c_ASCII_0 + {4'h0, i_nib};
    else               o_char = c_ALPHA + {4'h0, i_nib} - 8'd10;
  end

endmodule
`default_nettype wire

// File: rtl/literal_emitter.sv
`default_nettype none
// ============================================================================
// Module   : literal_emitter
// Brief    : Formats an accepted value as a SystemVerilog sized hex literal
//            (e.g. 32'h1234_abcd) and streams it one ASCII char per transfer.
// Revision : 1.0 - initial release
// ============================================================================
module literal_emitter
  import literal_emitter_pkg::*;
#(
  parameter int W_DATA = 32,
  parameter int GROUP  = 4,
  parameter int UPPER  = 0
) (
  input  logic              i_clk,
  input  logic              resetn,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [W_DATA-1:0] i_data,
  input  logic              i_signed,
  output logic [7:0]        o_char,
  output logic              o_valid,
  input  logic              i_char_ready,
  output logic              o_last
);

  localparam int c_NDIG = (W_DATA + 3) / 4;
  localparam int c_PADW = 4 * c_NDIG;
  localparam int c_NDEC = dec_count(W_DATA);
  localparam logic [4*c_DEC_MAX-1:0] c_DEC_DIGITS = dec_digits(W_DATA);
  localparam int c_CW   = 16;
  localparam int c_GRP  = (GROUP > 0) ? GROUP : 1;
  localparam bit c_GRP_EN = (GROUP > 0);

  localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);
  localparam logic [c_CW-1:0] c_DEC_LAST = c_CW'(c_NDEC - 1);
  localparam logic [c_CW-1:0] c_DIG_TOP  = c_CW'(c_NDIG - 1);
  localparam logic [c_CW-1:0] c_GRP_TOP  = c_CW'(c_GRP - 1);
  localparam logic [c_CW-1:0] c_GRP_INIT = c_CW'((c_NDIG - 1) % c_GRP);

  state_e            r_state;
  state_e            w_next;
  logic              r_up;
  logic [c_PADW-1:0] r_val;
  logic              r_sign;
  // WIDTH: index of the decimal digit on the output.
  // DIGIT: number of hex digits still to the right of the one on the output.
  logic [c_CW-1:0]   r_cnt;
  // Digits-to-the-right modulo GROUP; zero means an underscore follows.
  logic [c_CW-1:0]   r_grp;
  logic              w_accept;
  logic              w_xfer;
  logic              w_sep_due;
  logic [3:0]        w_dec;
  logic [7:0]        w_hex_char;

  assign w_accept  = i_valid && o_ready;
  assign w_xfer    = o_valid && i_char_ready;
  assign w_sep_due = c_GRP_EN && (r_grp == '0);

  hex_ascii #(
    .UPPER (UPPER)
  ) u_hex_ascii (
    .i_nib  (r_val[c_PADW-1 -: 4]),
    .o_char (w_hex_char)
  );

  // Select the current decimal digit of the width from the constant table.
  always_comb begin
    case (r_cnt[1:0])
      2'd0:    w_dec = c_DEC_DIGITS[15:12];
      2'd1:    w_dec = c_DEC_DIGITS[11:8];
      2'd2:    w_dec = c_DEC_DIGITS[7:4];
      default: w_dec = c_DEC_DIGITS[3:0];
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Holds o_ready low until the first cycle after reset is released.
  always_ff @(posedge i_clk) begin
    if (!resetn) r_up <= 1'b0;
    else         r_up <= 1'b1;
  end

  // Next-state logic; every emitting state moves only on a transfer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_WIDTH;
      ST_WIDTH: if (w_xfer && r_cnt == c_DEC_LAST) w_next = ST_TICK;
      ST_TICK:  if (w_xfer) w_next = r_sign ? ST_SIGN : ST_BASE;
      ST_SIGN:  if (w_xfer) w_next = ST_BASE;
      ST_BASE:  if (w_xfer) w_next = ST_DIGIT;
      ST_DIGIT: begin
        if (w_xfer) begin
          if (r_cnt == '0)    w_next = ST_IDLE;
          else if (w_sep_due) w_next = ST_SEP;
        end
      end
      ST_SEP:   if (w_xfer) w_next = ST_DIGIT;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Capture on accept; step digit counters and shift the value on transfers.
  always_ff @(posedge i_clk) begin
    if (!resetn) begin
      r_val  <= '0;
      r_sign <= 1'b0;
      r_cnt  <= '0;
      r_grp  <= '0;
    end else if (w_accept) begin
      r_val  <= c_PADW'(i_data);
      r_sign <= i_signed;
      r_cnt  <= '0;
    end else if (w_xfer) begin
      case (r_state)
        ST_WIDTH: begin
          if (r_cnt == c_DEC_LAST) begin
            r_cnt <= c_DIG_TOP;
            r_grp <= c_GRP_INIT;
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end
        ST_DIGIT: begin
          r_val <= r_val << 4;
          r_cnt <= r_cnt - c_ONE;
          r_grp <= (r_grp == '0) ? c_GRP_TOP : r_grp - c_ONE;
        end
        default: ;
      endcase
    end
  end

  // Output decode; all outputs derive from registers so they hold in a stall.
  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_last  = 1'b0;
    o_char  = 8'h00;
    case (r_state)
      ST_IDLE:  o_ready = r_up;
      ST_WIDTH: begin o_valid = 1'b1; o_char = c_ASCII_0 | {4'h0, w_dec}; end
      ST_TICK:  begin o_valid = 1'b1; o_char = c_ASCII_TICK; end
      ST_SIGN:  begin o_valid = 1'b1; o_char = c_ASCII_S; end
      ST_BASE:  begin o_valid = 1'b1; o_char = c_ASCII_H; end
      ST_DIGIT: begin
        o_valid = 1'b1;
        o_char  = w_hex_char;
        o_last  = (r_cnt == '0);
      end
      ST_SEP:   begin o_valid = 1'b1; o_char = c_ASCII_US; end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_literal_emitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_literal_emitter
// Brief    : Directed self-checking bench for literal_emitter across several
//            parameter sets sharing one stimulus bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_literal_emitter;

  logic        clk;
  logic        resetn;
  logic        i_valid;
  logic        i_signed;
  logic        i_char_ready;
  logic [47:0] d;
  logic [7:0]  w_char [6];
  logic        w_val  [6];
  logic        w_lst  [6];
  logic        w_rdy  [6];

  int n_checks;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  literal_emitter #(.W_DATA(32), .GROUP(4), .UPPER(0)) u_w32 (
    .i_clk(clk), .resetn(resetn), .i_valid(i_valid), .o_ready(w_rdy[0]),
    .i_data(d[31:0]), .i_signed(i_signed), .o_char(w_char[0]), .o_valid(w_val[0]),
    .i_char_ready(i_char_ready), .o_last(w_lst[0]));
  literal_emitter #(.W_DATA(8), .GROUP(4), .UPPER(0)) u_w8 (
    .i_clk(clk), .resetn(resetn), .i_valid(i_valid), .o_ready(w_rdy[1]),
    .i_data(d[7:0]), .i_signed(i_signed), .o_char(w_char[1]), .o_valid(w_val[1]),
    .i_char_ready(i_char_ready), .o_last(w_lst[1]));
  literal_emitter #(.W_DATA(8), .GROUP(4), .UPPER(1)) u_w8u (
    .i_clk(clk), .resetn(resetn), .i_valid(i_valid), .o_ready(w_rdy[2]),
    .i_data(d[7:0]), .i_signed(i_signed), .o_char(w_char[2]), .o_valid(w_val[2]),
    .i_char_ready(i_char_ready), .o_last(w_lst[2]));
  literal_emitter #(.W_DATA(48), .GROUP(4), .UPPER(0)) u_w48 (
    .i_clk(clk), .resetn(resetn), .i_valid(i_valid), .o_ready(w_rdy[3]),
    .i_data(d[47:0]), .i_signed(i_signed), .o_char(w_char[3]), .o_valid(w_val[3]),
    .i_char_ready(i_char_ready), .o_last(w_lst[3]));
  literal_emitter #(.W_DATA(5), .GROUP(0), .UPPER(0)) u_w5 (
    .i_clk(clk), .resetn(resetn), .i_valid(i_valid), .o_ready(w_rdy[4]),
    .i_data(d[4:0]), .i_signed(i_signed), .o_char(w_char[4]), .o_valid(w_val[4]),
    .i_char_ready(i_char_ready), .o_last(w_lst[4]));
  literal_emitter #(.W_DATA(20), .GROUP(4), .UPPER(0)) u_w20 (
    .i_clk(clk), .resetn(resetn), .i_valid(i_valid), .o_ready(w_rdy[5]),
    .i_data(d[19:0]), .i_signed(i_signed), .o_char(w_char[5]), .o_valid(w_val[5]),
    .i_char_ready(i_char_ready), .o_last(w_lst[5]));

  // Reset all instances; returns on the edge where resetn is sampled high.
  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; i_valid = 1'b0; i_char_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
  endtask

  // Offer a value and return on the edge where instance k accepts it.
  task automatic accept(input int k, input logic [47:0] data, input logic sgn);
    int n;
    n = 0;
    @(negedge clk);
    d = data; i_signed = sgn; i_valid = 1'b1;
    while (w_rdy[k] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
  endtask

  // Gather characters of instance k until o_last (or maxc chars); records
  // stall stability, o_ready during emission and first-valid cycle.
  task automatic collect(input int k, input bit toggle, input bit hold,
                         input logic [47:0] new_data, input int maxc,
                         output string got, output int first_at,
                         output bit last_seen, output int stall_bad,
                         output int ready_bad, output bit timeout);
    logic [7:0] pc;
    logic pl, pst, rdy;
    int n;
    got = ""; first_at = -1; last_seen = 1'b0; stall_bad = 0; ready_bad = 0;
    timeout = 1'b1; pst = 1'b0; pc = 8'h00; pl = 1'b0; n = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        i_valid = hold;
        if (hold) d = new_data;
      end
      if (pst && (w_val[k] !== 1'b1 || w_char[k] !== pc || w_lst[k] !== pl)) stall_bad++;
      if (w_rdy[k] !== 1'b0) ready_bad++;
      if (w_val[k] === 1'b1 && first_at < 0) first_at = cyc;
      rdy = toggle ? (cyc % 2 == 0) : 1'b1;
      i_char_ready = rdy;
      pst = (w_val[k] === 1'b1) && !rdy;
      pc = w_char[k];
      pl = w_lst[k];
      if (w_val[k] === 1'b1 && rdy) begin
        got = {got, $sformatf("%c", w_char[k])};
        n++;
        if (w_lst[k] === 1'b1) last_seen = 1'b1;
        if (w_lst[k] === 1'b1 || n == maxc) begin
          timeout = 1'b0;
          @(posedge clk);
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0; i_valid = 1'b1; i_char_ready = 1'b1; d = 48'h0; i_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (w_val[0] !== 1'b0 || w_lst[0] !== 1'b0) begin
      n_err++; $display("FAIL reset_valid_last: got valid=%b last=%b expected 0 0", w_val[0], w_lst[0]);
    end
    n_checks++;
    if (w_rdy[0] !== 1'b0) begin
      n_err++; $display("FAIL reset_ready: got %b expected 0", w_rdy[0]);
    end
    n_checks++;
    if (w_char[0] !== 8'h00) begin
      n_err++; $display("FAIL reset_char: got %h expected 00", w_char[0]);
    end
    i_valid = 1'b0;
    resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (w_rdy[0] !== 1'b1) begin
      n_err++; $display("FAIL reset_ready_rise: got %b expected 1", w_rdy[0]);
    end
  endtask

  task automatic test_basic();
    string got; int fa, sb, rb; bit ls, to;
    do_reset();
    accept(0, 48'h1234abcd, 1'b0);
    collect(0, 1'b0, 1'b0, 48'h0, 100, got, fa, ls, sb, rb, to);
    n_checks++;
    if (got != "32'h1234_abcd" || to) begin
      n_err++; $display("FAIL basic_text: got \"%s\" expected \"32'h1234_abcd\"", got);
    end
    n_checks++;
    if (fa !== 0) begin
      n_err++; $display("FAIL basic_first_latency: got %0d expected 0", fa);
    end
    n_checks++;
    if (!ls || rb !== 0) begin
      n_err++; $display("FAIL basic_last_ready: got last=%b ready_hi=%0d expected 1 0", ls, rb);
    end
    accept(0, 48'hdeadbeef, 1'b1);
    collect(0, 1'b0, 1'b0, 48'h0, 100, got, fa, ls, sb, rb, to);
    n_checks++;
    if (got != "32'shdead_beef" || to) begin
      n_err++; $display("FAIL signed32_text: got \"%s\" expected \"32'shdead_beef\"", got);
    end
  endtask

  task automatic test_signed_upper();
    string got; int fa, sb, rb; bit ls, to;
    do_reset();
    accept(1, 48'ha5, 1'b1);
    collect(1, 1'b0, 1'b0, 48'h0, 100, got, fa, ls, sb, rb, to);
    n_checks++;
    if (got != "8'sha5" || to) begin
      n_err++; $display("FAIL signed8_text: got \"%s\" expected \"8'sha5\"", got);
    end
    do_reset();
    accept(2, 48'ha5, 1'b1);
    collect(2, 1'b0, 1'b0, 48'h0, 100, got, fa, ls, sb, rb, to);
    n_checks++;
    if (got != "8'shA5" || to) begin
      n_err++; $display("FAIL upper8_text: got \"%s\" expected \"8'shA5\"", got);
    end
  endtask

  task automatic test_stall();
    string got; int fa, sb, rb; bit ls, to;
    do_reset();
    accept(3, 48'h1234abcdef69, 1'b0);
    collect(3, 1'b1, 1'b0, 48'h0, 100, got, fa, ls, sb, rb, to);
    n_checks++;
    if (got != "48'h1234_abcd_ef69" || to) begin
      n_err++; $display("FAIL stall_text: got \"%s\" expected \"48'h1234_abcd_ef69\"", got);
    end
    n_checks++;
    if (sb !== 0) begin
      n_err++; $display("FAIL stall_stable: got %0d unstable cycles expected 0", sb);
    end
    n_checks++;
    if (!ls) begin
      n_err++; $display("FAIL stall_last: got %b expected 1", ls);
    end
  endtask

  task automatic test_widths();
    string got; int fa, sb, rb; bit ls, to;
    do_reset();
    accept(4, 48'h1f, 1'b0);
    collect(4, 1'b0, 1'b0, 48'h0, 100, got, fa, ls, sb, rb, to);
    n_checks++;
    if (got != "5'h1f" || to) begin
      n_err++; $display("FAIL nogroup_text: got \"%s\" expected \"5'h1f\"", got);
    end
    do_reset();
    accept(5, 48'h00001, 1'b0);
    collect(5, 1'b0, 1'b0, 48'h0, 100, got, fa, ls, sb, rb, to);
    n_checks++;
    if (got != "20'h0_0001" || to) begin
      n_err++; $display("FAIL leadzero_text: got \"%s\" expected \"20'h0_0001\"", got);
    end
  endtask

  task automatic test_back_to_back();
    string got; int fa, sb, rb; bit ls, to;
    do_reset();
    accept(0, 48'h0000ffff, 1'b0);
    collect(0, 1'b0, 1'b1, 48'h89abcdef, 100, got, fa, ls, sb, rb, to);
    n_checks++;
    if (got != "32'h0000_ffff" || to) begin
      n_err++; $display("FAIL hold_first_text: got \"%s\" expected \"32'h0000_ffff\"", got);
    end
    n_checks++;
    if (rb !== 0) begin
      n_err++; $display("FAIL hold_ready_low: got %0d ready cycles expected 0", rb);
    end
    @(negedge clk);
    n_checks++;
    if (w_rdy[0] !== 1'b1) begin
      n_err++; $display("FAIL hold_ready_return: got %b expected 1", w_rdy[0]);
    end
    @(posedge clk);
    collect(0, 1'b0, 1'b0, 48'h0, 100, got, fa, ls, sb, rb, to);
    n_checks++;
    if (got != "32'h89ab_cdef" || to) begin
      n_err++; $display("FAIL hold_second_text: got \"%s\" expected \"32'h89ab_cdef\"", got);
    end
    n_checks++;
    if (fa !== 0) begin
      n_err++; $display("FAIL hold_second_latency: got %0d expected 0", fa);
    end
  endtask

  task automatic test_reset_mid();
    string got; int fa, sb, rb; bit ls, to;
    do_reset();
    accept(0, 48'h1234abcd, 1'b0);
    collect(0, 1'b0, 1'b0, 48'h0, 4, got, fa, ls, sb, rb, to);
    n_checks++;
    if (got != "32'h" || to) begin
      n_err++; $display("FAIL mid_prefix: got \"%s\" expected \"32'h\"", got);
    end
    @(negedge clk);
    resetn = 1'b0; i_char_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (w_val[0] !== 1'b0) begin
      n_err++; $display("FAIL mid_abort_valid: got %b expected 0", w_val[0]);
    end
    resetn = 1'b1; i_char_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (w_rdy[0] !== 1'b1) begin
      n_err++; $display("FAIL mid_ready_after: got %b expected 1", w_rdy[0]);
    end
    accept(0, 48'h1234abcd, 1'b0);
    collect(0, 1'b0, 1'b0, 48'h0, 100, got, fa, ls, sb, rb, to);
    n_checks++;
    if (got != "32'h1234_abcd" || to) begin
      n_err++; $display("FAIL mid_next_text: got \"%s\" expected \"32'h1234_abcd\"", got);
    end
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    resetn = 1'b0; i_valid = 1'b0; i_signed = 1'b0; i_char_ready = 1'b1; d = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic();
    test_signed_upper();
    test_stall();
    test_widths();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/literal_emitter.md
LITERAL_EMITTER -- requirements
Module: literal_emitter

Interface
REQ-001 The block SHALL have parameter W_DATA, default 32, giving the value width in bits (legal range 1..9999).
REQ-002 The block SHALL have parameter GROUP, default 4, giving hex digits per underscore group; 0 disables underscores.
REQ-003 The block SHALL have parameter UPPER, default 0, where 1 selects hex digits A-F instead of a-f.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port i_valid, input, 1 bit: a value is offered.
REQ-007 The block SHALL have port o_ready, output, 1 bit: the block accepts a value.
REQ-008 The block SHALL have port i_data, input, W_DATA bits: the value to format.
REQ-009 The block SHALL have port i_signed, input, 1 bit: emit the 's' signed marker; sampled with i_data.
REQ-010 The block SHALL have port o_char, output, 8 bits: ASCII character.
REQ-011 The block SHALL have port o_valid, output, 1 bit: o_char is valid.
REQ-012 The block SHALL have port i_char_ready, input, 1 bit: the sink takes o_char.
REQ-013 The block SHALL have port o_last, output, 1 bit: o_char is the final character of the literal.

Function
REQ-014 Acceptance SHALL occur on a cycle with i_valid=1 and o_ready=1; i_data and i_signed SHALL be captured then, and later changes SHALL be ignored.
REQ-015 Output sequence: W_DATA in decimal without leading zeros, "'", "s" only if i_signed=1, "h", then NDIG=ceil(W_DATA/4) hex digits MSB first.
REQ-016 The top hex digit SHALL be zero-extended; all NDIG digits SHALL be emitted, including leading zeros.
REQ-017 If GROUP>0, "_" SHALL be inserted between digits wherever the count of digits to its right is a nonzero multiple of GROUP; no leading or trailing "_".
REQ-018 A character SHALL transfer on a cycle with o_valid=1 and i_char_ready=1; with i_char_ready held high, one character SHALL transfer per cycle.
REQ-019 While o_valid=1 and i_char_ready=0, o_char, o_valid and o_last SHALL hold stable.
REQ-020 The first character SHALL have o_valid=1 in the cycle after acceptance.
REQ-021 o_last SHALL be 1 only with the final hex digit.
REQ-022 o_ready SHALL be 1 only in IDLE.
REQ-023 o_ready SHALL be 0 from acceptance until the cycle after the o_last transfer, when it returns to 1; acceptance never overlaps emission.
REQ-024 The state machine SHALL have states IDLE, WIDTH, TICK, SIGN, BASE, DIGIT and SEP.
REQ-025 Transitions: IDLE->WIDTH on accept; WIDTH->TICK after the last decimal digit; TICK->SIGN if signed, else BASE; SIGN->BASE; BASE->DIGIT; DIGIT->SEP at a group boundary, else DIGIT; SEP->DIGIT; final DIGIT->IDLE.
REQ-026 Each non-IDLE state SHALL advance only on an output transfer.
REQ-027 The decimal digits of W_DATA SHALL be elaboration-time constants; no runtime division.
REQ-028 W_DATA not a multiple of 4 SHALL be handled by zero-padding the captured value to 4*NDIG bits.

Reset
REQ-029 On resetn=0 at a clock edge: state SHALL be IDLE and o_valid=0, o_last=0, o_ready=0, o_char=8'h00; the captured value SHALL be cleared.
REQ-030 o_ready SHALL rise the first cycle after resetn is sampled high.
REQ-031 Reset mid-emission SHALL abort the literal; no further characters of it SHALL appear.

Structure
REQ-032 Package literal_emitter_pkg SHALL hold the state enum, ASCII constants ("'", "s", "h", "_", "0", "a"/"A"), and a constant function giving the decimal digit count and digits of W_DATA.
REQ-033 The block SHALL use one sub-module, hex_ascii: a combinational 4-bit nibble to ASCII converter with an UPPER parameter.

Verification
REQ-034 Case: W_DATA=32, i_data=32'h1234abcd, i_signed=0, sink always ready -> "32'h1234_abcd" on consecutive cycles, o_last on "d", 13 characters.
REQ-035 Case: W_DATA=8, i_data=8'hA5, i_signed=1 -> "8'sha5"; with UPPER=1 -> "8'shA5".
REQ-036 Case: W_DATA=48, i_data=48'h1234abcdef69, i_char_ready toggled 1/0 each cycle -> "48'h1234_abcd_ef69", outputs stable during stalls, no lost or duplicated characters.
REQ-037 Case: W_DATA=5, i_data=5'h1F, GROUP=0 -> "5'h1f".
REQ-038 Case: W_DATA=20, i_data=20'h00001 -> "20'h0_0001".
REQ-039 Case: i_valid held high with new i_data during emission -> i_data ignored; the next acceptance occurs the cycle after the o_last transfer.
REQ-040 Case: resetn=0 after the fourth character -> o_valid=0 next cycle; o_ready=1 the cycle after resetn is sampled high; the next literal is complete and correct.
